tape_ram_arb: RTL
=================

TAPE_RAM_ARB -- requirements
Module: tape_ram_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, byte-address width of all address ports.
REQ-002 SHALL have parameter RD_TIMEOUT, default 1023, the maximum number of clk cycles to wait for mem_dout_ready; 0 disables the timeout.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 dl_active  in  1  download in progress; blocks tape reads while high.
REQ-006 ld_wr  in  1  one-cycle loader write strobe.
REQ-007 ld_addr  in  ADDR_W  loader write address, sampled with ld_wr.
REQ-008 ld_data  in  8  loader write data, sampled with ld_wr.
REQ-009 ld_wait  out  1  loader stall; high while a loader write is pending or in flight.
REQ-010 tp_rd  in  1  one-cycle tape read strobe.
REQ-011 tp_addr  in  ADDR_W  tape read address, sampled with tp_rd.
REQ-012 tp_data  out  8  last read byte; held until the next completed read.
REQ-013 tp_valid  out  1  one-cycle pulse when tp_data is updated.
REQ-014 ready  out  1  high when the arbiter is idle with nothing pending.
REQ-015 err  out  1  sticky protocol-error or timeout flag; cleared only by reset.
REQ-016 mem_busy  in  1  memory cannot accept a command this cycle.
REQ-017 mem_addr  out  ADDR_W  command address.
REQ-018 mem_din  out  8  write data.
REQ-019 mem_we  out  1  write command, held until accepted.
REQ-020 mem_rd  out  1  read command, held until accepted.
REQ-021 mem_dout  in  8  read data.
REQ-022 mem_dout_ready  in  1  read data valid, one cycle.

Function
REQ-023 SHALL implement the states IDLE, WR_CMD, RD_CMD and RD_WAIT.
REQ-024 SHALL hold one pending slot per requester: ld_wr captures ld_addr/ld_data; tp_rd captures tp_addr.
REQ-025 ld_wait SHALL rise the cycle after ld_wr and fall the cycle after the write is accepted.
REQ-026 ld_wr while the loader slot is occupied SHALL be dropped, SHALL set err, and SHALL NOT change the captured address or data.
REQ-027 tp_rd while the tape slot is occupied or a read is in flight SHALL be dropped and SHALL set err.
REQ-028 IDLE with the loader slot pending -> WR_CMD; a loader request wins any simultaneous or co-pending tape request.
REQ-029 IDLE with only the tape slot pending and dl_active=0 -> RD_CMD; with dl_active=1 the tape request stays pending.
REQ-030 WR_CMD: mem_we=1 and mem_addr/mem_din come from the slot; acceptance is mem_we & !mem_busy; on acceptance the slot is freed and the state returns to IDLE.
REQ-031 RD_CMD: mem_rd=1 and mem_addr comes from the slot; on acceptance (!mem_busy) the slot is freed and the state goes to RD_WAIT.
REQ-032 RD_WAIT: on mem_dout_ready, tp_data <= mem_dout, tp_valid=1 for one cycle, and the state goes to IDLE.
REQ-033 RD_WAIT: after RD_TIMEOUT cycles without mem_dout_ready, the state goes to IDLE, err is set and no tp_valid pulse is issued.
REQ-034 A new command SHALL NOT issue before the state has returned to IDLE; back-to-back commands are separated by at least one IDLE cycle.
REQ-035 mem_dout_ready outside RD_WAIT SHALL be ignored: tp_data and tp_valid stay unchanged.
REQ-036 mem_we and mem_rd SHALL never be high in the same cycle.
REQ-037 mem_addr/mem_din SHALL be stable while mem_we or mem_rd is high.
REQ-038 ready = (state==IDLE) & both slots empty.
REQ-039 The timeout counter SHALL be ceil(log2(RD_TIMEOUT+1)) bits, SHALL clear on entering RD_WAIT, and SHALL saturate without wrapping.

Reset
REQ-040 reset_n=0 SHALL immediately force state IDLE, both slots empty, counter 0, ld_wait=0, tp_valid=0, tp_data=0, err=0, mem_we=0, mem_rd=0, mem_addr=0, mem_din=0 and ready=1.
REQ-041 Reset mid-operation SHALL discard pending and in-flight requests; a mem_dout_ready arriving after reset is ignored (REQ-035).

Verification
REQ-042 ld_wr addr=0x000010 data=0xA5 with mem_busy=0 -> mem_we=1 next cycle with addr 0x10 and din 0xA5; ld_wait high for exactly 2 cycles.
REQ-043 ld_wr and tp_rd in the same cycle -> write issued first; read issued only after an IDLE cycle; tp_valid pulses once with the returned byte 0x3C.
REQ-044 mem_busy held high 5 cycles during WR_CMD -> mem_we and mem_addr stable for 6 cycles; ld_wait falls the cycle after acceptance.
REQ-045 tp_rd with dl_active=1 for 10 cycles -> no mem_rd; mem_rd asserts the cycle after dl_active falls.
REQ-046 RD_TIMEOUT=8 with no mem_dout_ready -> IDLE after 8 cycles; err=1; no tp_valid; a later stray mem_dout_ready leaves tp_data unchanged.
REQ-047 reset_n pulsed low in RD_WAIT, then mem_dout_ready=1 with data 0xFF -> tp_data stays 0x00, tp_valid stays 0, ready=1.

Source files
------------

// File: rtl/tape_ram_arb.sv
// Arbitrates a byte-wide RAM port between a loader (writes) and a tape reader (reads).
// Each requester owns a single pending slot; the loader wins whenever both are pending.
module tape_ram_arb #(
  parameter int ADDR_W     = 25,
  parameter int RD_TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic              ld_wr,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_wait,
  input  logic              tp_rd,
  input  logic [ADDR_W-1:0] tp_addr,
  output logic [7:0]        tp_data,
  output logic              tp_valid,
  output logic              ready,
  output logic              err,
  input  logic              mem_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  output logic              mem_rd,
  input  logic [7:0]        mem_dout,
  input  logic              mem_dout_ready
);

  localparam int CNT_W = (RD_TIMEOUT > 0) ? $clog2(RD_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = (RD_TIMEOUT > 0) ? CNT_W'(RD_TIMEOUT - 1) : '0;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WR_CMD  = 2'd1;
  localparam logic [1:0] RD_CMD  = 2'd2;
  localparam logic [1:0] RD_WAIT = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              ld_pend;
  logic [ADDR_W-1:0] ld_addr_q;
  logic [7:0]        ld_data_q;
  logic              tp_pend;
  logic [ADDR_W-1:0] tp_addr_q;

  logic wr_accept;
  logic rd_accept;
  logic rd_done;
  logic rd_timeout;
  logic ld_drop;
  logic tp_drop;

  // A tape read in RD_WAIT is still in flight even though its slot was already freed.
  assign ld_drop = ld_wr & ld_pend;
  assign tp_drop = tp_rd & (tp_pend | (state == RD_WAIT));

  always_comb begin
    state_nxt  = state;
    wr_accept  = 1'b0;
    rd_accept  = 1'b0;
    rd_done    = 1'b0;
    rd_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (ld_pend) begin
          state_nxt = WR_CMD;
        end else if (tp_pend && !dl_active) begin
          state_nxt = RD_CMD;
        end
      end
      WR_CMD: begin
        if (!mem_busy) begin
          wr_accept = 1'b1;
          state_nxt = IDLE;
        end
      end
      RD_CMD: begin
        if (!mem_busy) begin
          rd_accept = 1'b1;
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (mem_dout_ready) begin
          rd_done   = 1'b1;
          state_nxt = IDLE;
        end else if ((RD_TIMEOUT != 0) && (cnt == CNT_LAST)) begin
          rd_timeout = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (rd_accept) begin
        cnt <= '0;
      end else if ((state == RD_WAIT) && (cnt != CNT_MAX)) begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  // A strobe that hits an occupied slot is dropped without touching the captured request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_pend   <= 1'b0;
      ld_addr_q <= '0;
      ld_data_q <= '0;
      tp_pend   <= 1'b0;
      tp_addr_q <= '0;
    end else begin
      if (ld_wr && !ld_pend) begin
        ld_pend   <= 1'b1;
        ld_addr_q <= ld_addr;
        ld_data_q <= ld_data;
      end else if (wr_accept) begin
        ld_pend <= 1'b0;
      end
      if (tp_rd && !tp_drop) begin
        tp_pend   <= 1'b1;
        tp_addr_q <= tp_addr;
      end else if (rd_accept) begin
        tp_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tp_data  <= '0;
      tp_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      tp_valid <= rd_done;
      if (rd_done) begin
        tp_data <= mem_dout;
      end
      if (ld_drop || tp_drop || rd_timeout) begin
        err <= 1'b1;
      end
    end
  end

  // Command outputs come straight from the state and the slot registers, so they hold until accepted.
  always_comb begin
    mem_addr = '0;
    case (state)
      WR_CMD:  mem_addr = ld_addr_q;
      RD_CMD:  mem_addr = tp_addr_q;
      default: mem_addr = '0;
    endcase
  end

  assign mem_we  = (state == WR_CMD);
  assign mem_rd  = (state == RD_CMD);
  assign mem_din = mem_we ? ld_data_q : 8'h00;
  assign ld_wait = ld_pend;
  assign ready   = (state == IDLE) && !ld_pend && !tp_pend;

endmodule
